// File: rtl/beep_ctrl.sv
// beep_ctrl: alarm cadence sequencer for the buzzer path.
// Registers the water-level class and plays N beeps per burst for level N,
// followed by a silent gap, repeating. A timed operator mute silences the
// pattern and is cancelled early if the level escalates past the muted level.
// All phase timing derives from an internal tick prescaler.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   level        water-level class (0 = no alarm, 1..7 = severity)
//   level_valid  one-cycle strobe; level is captured when high
//   mute         one-cycle operator mute pulse
//   beep_en      buzzer enable
//   beep_state   tone select to buzzer, 0 = silent
//   alarm_active high whenever the sequencer is not idle
//   muted        high while muted
module beep_ctrl #(
  parameter int TICK_DIV   = 50000,
  parameter int ON_TICKS   = 20,
  parameter int OFF_TICKS  = 10,
  parameter int GAP_TICKS  = 100,
  parameter int MUTE_TICKS = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] level,
  input  logic       level_valid,
  input  logic       mute,
  output logic       beep_en,
  output logic [2:0] beep_state,
  output logic       alarm_active,
  output logic       muted
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_GAP,
    S_MUTED
  } state_t;

  state_t        state, nxt;
  logic [2:0]    lvl_q;
  logic [2:0]    burst_lvl, nxt_burst_lvl;
  logic [2:0]    beeps_left, nxt_beeps_left;
  logic [2:0]    mute_lvl, nxt_mute_lvl;
  logic [PW-1:0] presc;
  logic [31:0]   timer;
  logic [31:0]   timer_load;
  logic          tick;
  logic          expire;
  logic          enter;

  assign tick   = (presc == PW'(TICK_DIV - 1));
  assign expire = tick && (timer == 32'd1);

  // Priority: level cleared > mute > escalation > timer expiry.
  always_comb begin
    nxt            = state;
    enter          = 1'b0;
    nxt_burst_lvl  = burst_lvl;
    nxt_beeps_left = beeps_left;
    nxt_mute_lvl   = mute_lvl;
    case (state)
      S_IDLE: begin
        if (lvl_q != 3'd0) begin
          nxt            = S_ON;
          enter          = 1'b1;
          nxt_burst_lvl  = lvl_q;
          nxt_beeps_left = lvl_q;
        end
      end
      S_ON, S_OFF, S_GAP: begin
        if (lvl_q == 3'd0) begin
          nxt   = S_IDLE;
          enter = 1'b1;
        end else if (mute) begin
          nxt          = S_MUTED;
          enter        = 1'b1;
          nxt_mute_lvl = lvl_q;
        end else if (expire) begin
          enter = 1'b1;
          case (state)
            S_ON: nxt = S_OFF;
            S_OFF: begin
              nxt_beeps_left = beeps_left - 3'd1;
              nxt            = (beeps_left > 3'd1) ? S_ON : S_GAP;
            end
            default: begin
              nxt            = S_ON;
              nxt_burst_lvl  = lvl_q;
              nxt_beeps_left = lvl_q;
            end
          endcase
        end
      end
      S_MUTED: begin
        if (lvl_q == 3'd0) begin
          nxt   = S_IDLE;
          enter = 1'b1;
        end else if (mute) begin
          // Re-entering MUTED restarts the mute window.
          nxt          = S_MUTED;
          enter        = 1'b1;
          nxt_mute_lvl = lvl_q;
        end else if (lvl_q > mute_lvl || expire) begin
          nxt   = S_IDLE;
          enter = 1'b1;
        end
      end
      default: begin
        nxt   = S_IDLE;
        enter = 1'b1;
      end
    endcase
  end

  always_comb begin
    timer_load = '0;
    case (nxt)
      S_ON:    timer_load = 32'(ON_TICKS);
      S_OFF:   timer_load = 32'(OFF_TICKS);
      S_GAP:   timer_load = 32'(GAP_TICKS);
      S_MUTED: timer_load = 32'(MUTE_TICKS);
      default: timer_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      lvl_q      <= '0;
      burst_lvl  <= '0;
      beeps_left <= '0;
      mute_lvl   <= '0;
      presc      <= '0;
      timer      <= '0;
    end else begin
      state      <= nxt;
      burst_lvl  <= nxt_burst_lvl;
      beeps_left <= nxt_beeps_left;
      mute_lvl   <= nxt_mute_lvl;
      if (level_valid) lvl_q <= level;
      if (enter) begin
        presc <= '0;
        timer <= timer_load;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick && timer != '0) timer <= timer - 32'd1;
      end
    end
  end

  // Outputs are decoded from the next state so they change on the entry edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beep_en      <= 1'b0;
      beep_state   <= '0;
      alarm_active <= 1'b0;
      muted        <= 1'b0;
    end else begin
      beep_en      <= (nxt == S_ON);
      beep_state   <= (nxt == S_ON) ? nxt_burst_lvl : 3'd0;
      alarm_active <= (nxt != S_IDLE);
      muted        <= (nxt == S_MUTED);
    end
  end

endmodule

// File: tb/tb_beep_ctrl.sv
module tb_beep_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] level;
  logic       level_valid;
  logic       mute;
  logic       beep_en;
  logic [2:0] beep_state;
  logic       alarm_active;
  logic       muted;

  int checks = 0;
  int errors = 0;

  beep_ctrl #(
    .TICK_DIV  (4),
    .ON_TICKS  (2),
    .OFF_TICKS (1),
    .GAP_TICKS (3),
    .MUTE_TICKS(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .level       (level),
    .level_valid (level_valid),
    .mute        (mute),
    .beep_en     (beep_en),
    .beep_state  (beep_state),
    .alarm_active(alarm_active),
    .muted       (muted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One segment: optional reset first, strobes driven before the first edge,
  // then n edges each followed by a check of {beep_en, beep_state, alarm_active, muted}.
  typedef struct {
    bit         do_rst;
    bit         lv;
    logic [2:0] lvl;
    bit         m;
    int         n;
    logic [5:0] exp;
  } seg_t;

  seg_t segs[$];

  function automatic void add(bit r, bit lv, logic [2:0] l, bit m, int n,
                              bit en, logic [2:0] st, bit act, bit mu);
    seg_t s;
    s.do_rst = r;
    s.lv     = lv;
    s.lvl    = l;
    s.m      = m;
    s.n      = n;
    s.exp    = {en, st, act, mu};
    segs.push_back(s);
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {beep_en, beep_state, alarm_active, muted};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got en=%0b st=%0d act=%0b mu=%0b, expected en=%0b st=%0d act=%0b mu=%0b",
               name, got[5], got[4:2], got[1], got[0], exp[5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic do_reset(input string name);
    rst = 1'b0;
    #1;
    check(name, 6'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs level 3 through one full burst (ON/OFF x3) and 4 cycles into GAP.
  function automatic void add_burst3_into_gap();
    add(1, 1, 3'd3, 0, 1, 0, 3'd0, 0, 0);
    for (int b = 0; b < 3; b++) begin
      add(0, 0, 3'd0, 0, 8, 1, 3'd3, 1, 0);
      add(0, 0, 3'd0, 0, 4, 0, 3'd0, 1, 0);
    end
    add(0, 0, 3'd0, 0, 4, 0, 3'd0, 1, 0);
  endfunction

  initial begin
    rst         = 1'b0;
    level       = '0;
    level_valid = 1'b0;
    mute        = 1'b0;

    // Level 2: 8 on, 4 off, 8 on, 4 off, 12 gap, repeating every 36 cycles.
    add(1, 1, 3'd2, 0, 1, 0, 3'd0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      add(0, 0, 3'd0, 0, 8,  1, 3'd2, 1, 0);
      add(0, 0, 3'd0, 0, 4,  0, 3'd0, 1, 0);
      add(0, 0, 3'd0, 0, 8,  1, 3'd2, 1, 0);
      add(0, 0, 3'd0, 0, 4,  0, 3'd0, 1, 0);
      add(0, 0, 3'd0, 0, 12, 0, 3'd0, 1, 0);
    end
    add(0, 0, 3'd0, 0, 8, 1, 3'd2, 1, 0);

    // Level 7, then level 1 mid third beep: burst of 7 finishes, next burst is 1 beep.
    add(1, 1, 3'd7, 0, 1, 0, 3'd0, 0, 0);
    for (int b = 0; b < 2; b++) begin
      add(0, 0, 3'd0, 0, 8, 1, 3'd7, 1, 0);
      add(0, 0, 3'd0, 0, 4, 0, 3'd0, 1, 0);
    end
    add(0, 0, 3'd0, 0, 4, 1, 3'd7, 1, 0);
    add(0, 1, 3'd1, 0, 4, 1, 3'd7, 1, 0);
    add(0, 0, 3'd0, 0, 4, 0, 3'd0, 1, 0);
    for (int b = 3; b < 7; b++) begin
      add(0, 0, 3'd0, 0, 8, 1, 3'd7, 1, 0);
      add(0, 0, 3'd0, 0, 4, 0, 3'd0, 1, 0);
    end
    add(0, 0, 3'd0, 0, 12, 0, 3'd0, 1, 0);
    add(0, 0, 3'd0, 0, 8,  1, 3'd1, 1, 0);
    add(0, 0, 3'd0, 0, 4,  0, 3'd0, 1, 0);
    add(0, 0, 3'd0, 0, 12, 0, 3'd0, 1, 0);
    add(0, 0, 3'd0, 0, 8,  1, 3'd1, 1, 0);

    // Level 0 strobed mid-ON: one more ON cycle, then idle for good.
    add(1, 1, 3'd3, 0, 1,  0, 3'd0, 0, 0);
    add(0, 0, 3'd0, 0, 4,  1, 3'd3, 1, 0);
    add(0, 1, 3'd0, 0, 1,  1, 3'd3, 1, 0);
    add(0, 0, 3'd0, 0, 20, 0, 3'd0, 0, 0);

    // Mute in GAP: 20 muted cycles, one idle cycle, then ON again.
    add_burst3_into_gap();
    add(0, 0, 3'd0, 1, 20, 0, 3'd0, 1, 1);
    add(0, 0, 3'd0, 0, 1,  0, 3'd0, 0, 0);
    add(0, 0, 3'd0, 0, 8,  1, 3'd3, 1, 0);

    // Escalation to 5 while muted at 3: muted drops at edge 2, ON at 5 at edge 3.
    add_burst3_into_gap();
    add(0, 0, 3'd0, 1, 5, 0, 3'd0, 1, 1);
    add(0, 1, 3'd5, 0, 1, 0, 3'd0, 1, 1);
    add(0, 0, 3'd0, 0, 1, 0, 3'd0, 0, 0);
    add(0, 0, 3'd0, 0, 8, 1, 3'd5, 1, 0);

    // Lower level while muted: mute runs its full course.
    add_burst3_into_gap();
    add(0, 0, 3'd0, 1, 5,  0, 3'd0, 1, 1);
    add(0, 1, 3'd2, 0, 15, 0, 3'd0, 1, 1);
    add(0, 0, 3'd0, 0, 1,  0, 3'd0, 0, 0);
    add(0, 0, 3'd0, 0, 8,  1, 3'd2, 1, 0);

    @(negedge clk);
    foreach (segs[s]) begin
      if (segs[s].do_rst) do_reset($sformatf("seg%0d.reset", s));
      for (int i = 0; i < segs[s].n; i++) begin
        if (i == 0) begin
          level_valid = segs[s].lv;
          if (segs[s].lv) level = segs[s].lvl;
          mute = segs[s].m;
        end
        @(posedge clk);
        @(negedge clk);
        level_valid = 1'b0;
        mute        = 1'b0;
        check($sformatf("seg%0d.%0d", s, i), segs[s].exp);
      end
    end

    // Asynchronous reset mid-ON clears outputs before the next edge.
    do_reset("async.pre");
    level       = 3'd3;
    level_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    level_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("async.on", {1'b1, 3'd3, 1'b1, 1'b0});
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async.clear", 6'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("async.idle%0d", i), 6'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
